m55_arb: RTL and testbench

M55_ARB -- requirements
Module: m55_arb

---
 rtl/m55_arb.sv | 158 +++++++++++++++
 tb/tb_m55_arb.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/m55_arb.sv
// Two-requester arbiter in front of the m55 5x5 word memory.
// One owner at a time; an unlocked owner yields to a waiting peer every
// cycle, and a locked owner is forced off after STARVE_MAX denied cycles.
module m55_arb #(
  parameter int unsigned STARVE_MAX = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        reqa,
  input  logic        reqb,
  input  logic        locka,
  input  logic        lockb,
  input  logic [2:0]  axa,
  input  logic [2:0]  aya,
  input  logic [2:0]  axb,
  input  logic [2:0]  ayb,
  input  logic [2:0]  wxa,
  input  logic [2:0]  wya,
  input  logic [2:0]  wxb,
  input  logic [2:0]  wyb,
  input  logic        wra,
  input  logic        wrb,
  input  logic [63:0] wda,
  input  logic [63:0] wdb,
  output logic        gnta,
  output logic        gntb,
  output logic [63:0] rda,
  output logic [63:0] rdb,
  output logic [2:0]  max,
  output logic [2:0]  may,
  output logic [2:0]  mwx,
  output logic [2:0]  mwy,
  output logic        mwr,
  output logic [63:0] mwd,
  input  logic [63:0] mrd,
  output logic        err
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StOwnA = 2'd1;
  localparam logic [1:0] StOwnB = 2'd2;

  // Last-served pointer encoding; reset value LastB makes A win the first tie.
  localparam logic LastA = 1'b0;
  localparam logic LastB = 1'b1;

  localparam logic [7:0] StarveMax = 8'(STARVE_MAX);

  logic [1:0] state_q, state_d;
  logic       last_q, last_d;
  logic [7:0] starve_q, starve_d;
  logic       err_q, err_d;

  logic       own_wr;
  logic       wr_in_range;

  // Next-state, starve counter and last-served pointer.
  always_comb begin
    state_d  = state_q;
    starve_d = 8'd0;  // cleared unless a locked owner is actively denying the peer
    case (state_q)
      StIdle: begin
        if (reqa && reqb) begin
          state_d = (last_q == LastA) ? StOwnB : StOwnA;
        end else if (reqa) begin
          state_d = StOwnA;
        end else if (reqb) begin
          state_d = StOwnB;
        end
      end
      StOwnA: begin
        if (!reqa) begin
          state_d = reqb ? StOwnB : StIdle;
        end else if (reqb) begin
          if (!locka || (starve_q == StarveMax)) begin
            state_d = StOwnB;
          end else begin
            starve_d = starve_q + 8'd1;
          end
        end
      end
      StOwnB: begin
        if (!reqb) begin
          state_d = reqa ? StOwnA : StIdle;
        end else if (reqa) begin
          if (!lockb || (starve_q == StarveMax)) begin
            state_d = StOwnA;
          end else begin
            starve_d = starve_q + 8'd1;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    last_d = last_q;
    if (state_d == StOwnA) begin
      last_d = LastA;
    end else if (state_d == StOwnB) begin
      last_d = LastB;
    end
  end

  // Memory-port mux driven from the current owner; idle drives all zeros.
  always_comb begin
    max    = 3'd0;
    may    = 3'd0;
    mwx    = 3'd0;
    mwy    = 3'd0;
    mwd    = 64'd0;
    own_wr = 1'b0;
    case (state_q)
      StOwnA: begin
        max    = axa;
        may    = aya;
        mwx    = wxa;
        mwy    = wya;
        mwd    = wda;
        own_wr = wra;
      end
      StOwnB: begin
        max    = axb;
        may    = ayb;
        mwx    = wxb;
        mwy    = wyb;
        mwd    = wdb;
        own_wr = wrb;
      end
      default: ;
    endcase
    wr_in_range = (mwx <= 3'd4) && (mwy <= 3'd4);
    mwr         = own_wr && wr_in_range;
    // Only a granted write can flag; writes from the non-owner never reach own_wr.
    err_d       = err_q || (own_wr && !wr_in_range);
  end

  // State registers with asynchronous reset so a grant drops immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      last_q   <= LastB;
      starve_q <= 8'd0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      starve_q <= starve_d;
      err_q    <= err_d;
    end
  end

  assign gnta = (state_q == StOwnA);
  assign gntb = (state_q == StOwnB);
  assign err  = err_q;
  assign rda  = mrd;
  assign rdb  = mrd;

endmodule

// File: tb/tb_m55_arb.sv
// Self-checking bench for m55_arb: directed scenarios then random traffic,
// compared every cycle against a rule-level reference model.
module tb_m55_arb;

  localparam int unsigned StarveMax = 15;

  logic        clk = 1'b0;
  logic        reset;
  logic        reqa, reqb, locka, lockb;
  logic [2:0]  axa, aya, axb, ayb, wxa, wya, wxb, wyb;
  logic        wra, wrb;
  logic [63:0] wda, wdb;
  logic        gnta, gntb;
  logic [63:0] rda, rdb;
  logic [2:0]  max, may, mwx, mwy;
  logic        mwr;
  logic [63:0] mwd, mrd;
  logic        err;

  m55_arb #(.STARVE_MAX(StarveMax)) dut (
    .clk(clk), .reset(reset),
    .reqa(reqa), .reqb(reqb), .locka(locka), .lockb(lockb),
    .axa(axa), .aya(aya), .axb(axb), .ayb(ayb),
    .wxa(wxa), .wya(wya), .wxb(wxb), .wyb(wyb),
    .wra(wra), .wrb(wrb), .wda(wda), .wdb(wdb),
    .gnta(gnta), .gntb(gntb), .rda(rda), .rdb(rdb),
    .max(max), .may(may), .mwx(mwx), .mwy(mwy),
    .mwr(mwr), .mwd(mwd), .mrd(mrd), .err(err)
  );

  always #5 clk = ~clk;

  // Stand-in for the m55 memory, driven only by the DUT's memory port.
  logic [63:0] mem [8][8];
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) for (int j = 0; j < 8; j++) mem[i][j] <= 64'd0;
    end else if (mwr) begin
      mem[mwx][mwy] <= mwd;
    end
  end
  assign mrd = mem[max][may];

  // Reference model: owner 0 = nobody, 1 = A, 2 = B.
  int          m_owner, m_last, m_starve;
  logic        m_err;
  logic [63:0] ref_mem [8][8];

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    reqa = 0; reqb = 0; locka = 0; lockb = 0;
    axa = 0; aya = 0; axb = 0; ayb = 0; wxa = 0; wya = 0; wxb = 0; wyb = 0;
    wra = 0; wrb = 0; wda = 0; wdb = 0;
  endtask

  // Assert reset asynchronously, check immediate effect, hold across one edge.
  task automatic do_reset();
    reset = 1'b1;
    #1;
    check("rst_gnta", gnta, 0);
    check("rst_gntb", gntb, 0);
    check("rst_mwr", mwr, 0);
    check("rst_err", err, 0);
    check("rst_addr", {max, may, mwx, mwy}, 0);
    check("rst_mwd", mwd, 0);
    m_owner = 0; m_last = 2; m_starve = 0; m_err = 1'b0;
    for (int i = 0; i < 8; i++) for (int j = 0; j < 8; j++) ref_mem[i][j] = 64'd0;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  // Compare outputs for the current owner, apply the arbitration rules, advance a clock.
  task automatic cycle();
    logic [2:0]  ex_ax, ex_ay, ex_wx, ex_wy;
    logic [63:0] ex_wd;
    logic        ex_wr, in_rng, mine, other, lock;
    int          nxt;
    #2;
    ex_ax = 0; ex_ay = 0; ex_wx = 0; ex_wy = 0; ex_wd = 0; ex_wr = 0;
    if (m_owner == 1) begin
      ex_ax = axa; ex_ay = aya; ex_wx = wxa; ex_wy = wya; ex_wd = wda; ex_wr = wra;
    end else if (m_owner == 2) begin
      ex_ax = axb; ex_ay = ayb; ex_wx = wxb; ex_wy = wyb; ex_wd = wdb; ex_wr = wrb;
    end
    in_rng = (ex_wx <= 4) && (ex_wy <= 4);
    check("gnta", gnta, m_owner == 1);
    check("gntb", gntb, m_owner == 2);
    check("excl", gnta & gntb, 0);
    check("max", max, ex_ax);
    check("may", may, ex_ay);
    check("mwx", mwx, ex_wx);
    check("mwy", mwy, ex_wy);
    check("mwd", mwd, ex_wd);
    check("mwr", mwr, ex_wr && in_rng);
    check("err", err, m_err);
    check("rda", rda, ref_mem[ex_ax][ex_ay]);
    check("rdb", rdb, ref_mem[ex_ax][ex_ay]);

    if (ex_wr && in_rng) ref_mem[ex_wx][ex_wy] = ex_wd;
    if (ex_wr && !in_rng) m_err = 1'b1;

    nxt = m_owner;
    if (m_owner == 0) begin
      if (reqa && reqb) nxt = (m_last == 1) ? 2 : 1;
      else if (reqa) nxt = 1;
      else if (reqb) nxt = 2;
      m_starve = 0;
    end else begin
      mine  = (m_owner == 1) ? reqa : reqb;
      other = (m_owner == 1) ? reqb : reqa;
      lock  = (m_owner == 1) ? locka : lockb;
      if (!mine) nxt = other ? 3 - m_owner : 0;
      else if (!other) m_starve = 0;
      else if (!lock || m_starve == int'(StarveMax)) nxt = 3 - m_owner;
      else m_starve++;
    end
    if (nxt != m_owner) m_starve = 0;
    if (nxt != 0) m_last = nxt;
    m_owner = nxt;
    @(posedge clk); #1;
  endtask

  int n;

  initial begin
    clear_inputs();
    do_reset();

    // Simultaneous requests after reset: A first, then strict alternation.
    reqa = 1; reqb = 1;
    cycle();
    check("alt0_a", gnta, 1);
    cycle();
    check("alt1_b", gntb, 1);
    cycle();
    check("alt2_a", gnta, 1);
    cycle();
    check("alt3_b", gntb, 1);

    // Locked A starves B for STARVE_MAX+1 cycles, then is forced off.
    clear_inputs();
    do_reset();
    reqa = 1; locka = 1; reqb = 1;
    cycle();
    n = 0;
    while (gnta && n < 40) begin
      n++;
      cycle();
    end
    check("starve_len", n, StarveMax + 1);
    check("starve_gntb", gntb, 1);

    // Granted in-range write, then read back.
    clear_inputs();
    do_reset();
    reqa = 1;
    cycle();
    wra = 1; wxa = 2; wya = 3; wda = 64'hDEAD_BEEF_0000_0001;
    #1 check("wr_mwr", mwr, 1);
    cycle();
    wra = 0; axa = 2; aya = 3;
    #1 check("rd_back", rda, 64'hDEAD_BEEF_0000_0001);
    cycle();

    // Out-of-range granted write flags err; ungranted write is dropped.
    wra = 1; wxa = 5; wya = 1;
    #1 check("oor_mwr", mwr, 0);
    cycle();
    check("oor_err", err, 1);
    wra = 0; wrb = 1; wxb = 1; wyb = 1; wdb = 64'h1234;
    #1 check("ungr_mwr", mwr, 0);
    cycle();
    check("err_sticky", err, 1);
    wrb = 0;
    cycle();

    // Reset during an owned write by B.
    clear_inputs();
    do_reset();
    reqb = 1;
    cycle();
    wrb = 1; wxb = 1; wyb = 1; wdb = 64'hCAFE;
    #1 check("b_mwr", mwr, 1);
    do_reset();
    clear_inputs();
    reqa = 1;
    #1 check("post_rst_idle", gnta, 0);
    cycle();
    check("post_rst_gnta", gnta, 1);

    // Random traffic with occasional resets.
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 63) == 0) do_reset();
      reqa = ($urandom_range(0, 9) < 7);
      reqb = ($urandom_range(0, 9) < 7);
      locka = ($urandom_range(0, 9) < 4);
      lockb = ($urandom_range(0, 9) < 4);
      axa = 3'($urandom_range(0, 7)); aya = 3'($urandom_range(0, 7));
      axb = 3'($urandom_range(0, 7)); ayb = 3'($urandom_range(0, 7));
      wxa = 3'($urandom_range(0, 5)); wya = 3'($urandom_range(0, 5));
      wxb = 3'($urandom_range(0, 5)); wyb = 3'($urandom_range(0, 5));
      wra = ($urandom_range(0, 9) < 3);
      wrb = ($urandom_range(0, 9) < 3);
      wda = {$urandom, $urandom};
      wdb = {$urandom, $urandom};
      cycle();
    end

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
